// File: rtl/nrzi_4b5b_deframer.sv
// nrzi_4b5b_deframer
// Sits after the NRZI/4B5B symbol decoder. It hunts for a two-nibble sync
// marker, reads a 12-bit word count, then packs payload nibbles MSN-first
// into 16-bit words tagged with start/end of frame. A symbol error or an
// illegal length aborts the frame with a one-cycle frame_err pulse, and the
// block then returns to hunting for sync.
module nrzi_4b5b_deframer #(
    parameter logic [3:0] SYNC0     = 4'h7,
    parameter logic [3:0] SYNC1     = 4'hF,
    parameter int         MAX_WORDS = 256
) (
    input  logic        clk80,
    input  logic        reset,
    input  logic [3:0]  din,
    input  logic        din_err,
    output logic [15:0] dout,
    output logic        dout_valid,
    output logic        sof,
    output logic        eof,
    output logic        frame_err,
    output logic        frame_active
);

    localparam logic [11:0] MAX_LEN = 12'(MAX_WORDS);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        SYNC    = 2'd1,
        LENGTH  = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  nib_cnt_q, nib_cnt_d;
    logic [11:0] word_cnt_q, word_cnt_d;
    logic [11:0] len_q, len_d;
    logic [11:0] word_sh_q, word_sh_d;
    logic [15:0] dout_q, dout_d;
    logic        dout_valid_q, dout_valid_d;
    logic        sof_q, sof_d;
    logic        eof_q, eof_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_active_q, frame_active_d;

    logic [11:0] len_full_s;
    logic [15:0] word_full_s;
    logic        last_word_s;

    // Values formed by appending the current nibble, plus the last-word test.
    always_comb begin
        len_full_s  = {len_q[7:0], din};
        word_full_s = {word_sh_q, din};
        last_word_s = (word_cnt_q == (len_q - 12'd1));
    end

    // Next-state, counter and output-strobe logic for the deframing FSM.
    always_comb begin
        state_d      = state_q;
        nib_cnt_d    = nib_cnt_q;
        word_cnt_d   = word_cnt_q;
        len_d        = len_q;
        word_sh_d    = word_sh_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sof_d        = 1'b0;
        eof_d        = 1'b0;
        frame_err_d  = 1'b0;

        case (state_q)
            HUNT: begin
                // Error symbols are never taken as the first sync nibble.
                if (!din_err && (din == SYNC0)) begin
                    state_d = SYNC;
                end else begin
                    state_d = HUNT;
                end
            end

            SYNC: begin
                if (din_err) begin
                    state_d = HUNT;
                end else if (din == SYNC1) begin
                    state_d   = LENGTH;
                    nib_cnt_d = 2'd0;
                    len_d     = 12'd0;
                end else if (din == SYNC0) begin
                    // Repeated first nibble (7,7,F) keeps the marker alive.
                    state_d = SYNC;
                end else begin
                    state_d = HUNT;
                end
            end

            LENGTH: begin
                if (din_err) begin
                    frame_err_d = 1'b1;
                    state_d     = HUNT;
                    nib_cnt_d   = 2'd0;
                end else begin
                    len_d = len_full_s;
                    if (nib_cnt_q == 2'd2) begin
                        nib_cnt_d  = 2'd0;
                        word_cnt_d = 12'd0;
                        if ((len_full_s == 12'd0) || (len_full_s > MAX_LEN)) begin
                            frame_err_d = 1'b1;
                            state_d     = HUNT;
                        end else begin
                            state_d = PAYLOAD;
                        end
                    end else begin
                        nib_cnt_d = nib_cnt_q + 2'd1;
                    end
                end
            end

            PAYLOAD: begin
                if (din_err) begin
                    // Partial word is dropped; words already sent stand.
                    frame_err_d = 1'b1;
                    state_d     = HUNT;
                    nib_cnt_d   = 2'd0;
                    word_cnt_d  = 12'd0;
                end else begin
                    word_sh_d = word_full_s[11:0];
                    nib_cnt_d = nib_cnt_q + 2'd1;
                    if (nib_cnt_q == 2'd3) begin
                        dout_d       = word_full_s;
                        dout_valid_d = 1'b1;
                        sof_d        = (word_cnt_q == 12'd0);
                        eof_d        = last_word_s;
                        if (last_word_s) begin
                            state_d    = HUNT;
                            word_cnt_d = 12'd0;
                        end else begin
                            word_cnt_d = word_cnt_q + 12'd1;
                        end
                    end else begin
                        word_cnt_d = word_cnt_q;
                    end
                end
            end

            default: begin
                state_d = HUNT;
            end
        endcase

        frame_active_d = (state_d == LENGTH) || (state_d == PAYLOAD);
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk80 or posedge reset) begin
        if (reset) begin
            state_q        <= HUNT;
            nib_cnt_q      <= 2'd0;
            word_cnt_q     <= 12'd0;
            len_q          <= 12'd0;
            word_sh_q      <= 12'd0;
            dout_q         <= 16'd0;
            dout_valid_q   <= 1'b0;
            sof_q          <= 1'b0;
            eof_q          <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            nib_cnt_q      <= nib_cnt_d;
            word_cnt_q     <= word_cnt_d;
            len_q          <= len_d;
            word_sh_q      <= word_sh_d;
            dout_q         <= dout_d;
            dout_valid_q   <= dout_valid_d;
            sof_q          <= sof_d;
            eof_q          <= eof_d;
            frame_err_q    <= frame_err_d;
            frame_active_q <= frame_active_d;
        end
    end

    assign dout         = dout_q;
    assign dout_valid   = dout_valid_q;
    assign sof          = sof_q;
    assign eof          = eof_q;
    assign frame_err    = frame_err_q;
    assign frame_active = frame_active_q;

endmodule

// File: tb/tb_nrzi_4b5b_deframer.sv
// Directed testbench for nrzi_4b5b_deframer. Each step drives one symbol,
// clocks it in and compares the registered outputs with hand-computed values.
// Flag vector order: {dout_valid, sof, eof, frame_err, frame_active}.
module tb_nrzi_4b5b_deframer;

    logic        clk80;
    logic        reset;
    logic [3:0]  din;
    logic        din_err;
    logic [15:0] dout;
    logic        dout_valid;
    logic        sof;
    logic        eof;
    logic        frame_err;
    logic        frame_active;

    int checks;
    int errors;
    int step_no;

    nrzi_4b5b_deframer #(
        .SYNC0     (4'h7),
        .SYNC1     (4'hF),
        .MAX_WORDS (256)
    ) dut (
        .clk80        (clk80),
        .reset        (reset),
        .din          (din),
        .din_err      (din_err),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .sof          (sof),
        .eof          (eof),
        .frame_err    (frame_err),
        .frame_active (frame_active)
    );

    // 80 MHz-style free-running clock.
    initial clk80 = 1'b0;
    always #5 clk80 = ~clk80;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one symbol, clock it in, then check flags (and dout when a strobe is expected).
    task automatic cyc(input logic [3:0] nib, input logic err,
                       input logic [4:0] exp_flags, input logic [15:0] exp_dout);
        din     = nib;
        din_err = err;
        @(posedge clk80);
        #1;
        step_no++;
        check($sformatf("step%0d flags", step_no),
              {11'd0, dout_valid, sof, eof, frame_err, frame_active}, {11'd0, exp_flags});
        if (exp_flags[4]) begin
            check($sformatf("step%0d dout", step_no), dout, exp_dout);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        step_no = 0;
        reset   = 1'b1;
        din     = 4'hA;
        din_err = 1'b0;
        repeat (3) @(posedge clk80);
        #1;
        check("reset flags", {11'd0, dout_valid, sof, eof, frame_err, frame_active}, 16'd0);
        check("reset dout", dout, 16'h0000);
        reset = 1'b0;

        // Idle stream stays quiet.
        cyc(4'hA, 1'b0, 5'b00000, 16'h0);
        cyc(4'hA, 1'b0, 5'b00000, 16'h0);
        cyc(4'hA, 1'b0, 5'b00000, 16'h0);
        check("idle dout", dout, 16'h0000);

        // Two-word frame: 0x1234 (sof), 0xABCD (eof).
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h2, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'h2, 1'b0, 5'b00001, 16'h0);
        cyc(4'h3, 1'b0, 5'b00001, 16'h0);
        cyc(4'h4, 1'b0, 5'b11001, 16'h1234);
        cyc(4'hA, 1'b0, 5'b00001, 16'h0);
        cyc(4'hB, 1'b0, 5'b00001, 16'h0);
        cyc(4'hC, 1'b0, 5'b00001, 16'h0);
        cyc(4'hD, 1'b0, 5'b10100, 16'hABCD);
        cyc(4'hA, 1'b0, 5'b00000, 16'h0);

        // Repeated SYNC0, single-word frame: sof and eof together.
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'h5, 1'b0, 5'b00001, 16'h0);
        cyc(4'h6, 1'b0, 5'b00001, 16'h0);
        cyc(4'h7, 1'b0, 5'b00001, 16'h0);
        cyc(4'h8, 1'b0, 5'b11100, 16'h5678);

        // Broken marker 7,3,F never starts a frame.
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'h3, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00000, 16'h0);
        cyc(4'hA, 1'b0, 5'b00000, 16'h0);

        // Length 0 is rejected.
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00010, 16'h0);
        cyc(4'hA, 1'b0, 5'b00000, 16'h0);

        // Length 0x101 exceeds 256 words and is rejected.
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00010, 16'h0);
        cyc(4'hA, 1'b0, 5'b00000, 16'h0);

        // Length 3, symbol error on 2nd nibble of word 1. The errored symbol
        // is 7 and the next is F: neither may start a new frame.
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h3, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b11001, 16'h1111);
        cyc(4'h2, 1'b0, 5'b00001, 16'h0);
        cyc(4'h7, 1'b1, 5'b00010, 16'h0);
        cyc(4'hF, 1'b0, 5'b00000, 16'h0);
        cyc(4'h1, 1'b0, 5'b00000, 16'h0);
        cyc(4'h2, 1'b0, 5'b00000, 16'h0);
        cyc(4'h3, 1'b0, 5'b00000, 16'h0);
        cyc(4'h4, 1'b0, 5'b00000, 16'h0);

        // Error symbol in HUNT carrying SYNC0 is ignored.
        cyc(4'h7, 1'b1, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00000, 16'h0);

        // Valid frame after the abort decodes correctly.
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'h9, 1'b0, 5'b00001, 16'h0);
        cyc(4'h8, 1'b0, 5'b00001, 16'h0);
        cyc(4'h7, 1'b0, 5'b00001, 16'h0);
        cyc(4'h6, 1'b0, 5'b11100, 16'h9876);

        // Two len-1 frames with zero gap.
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'hC, 1'b0, 5'b00001, 16'h0);
        cyc(4'hA, 1'b0, 5'b00001, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'hE, 1'b0, 5'b11100, 16'hCAFE);
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'hB, 1'b0, 5'b00001, 16'h0);
        cyc(4'hE, 1'b0, 5'b00001, 16'h0);
        cyc(4'hE, 1'b0, 5'b00001, 16'h0);
        cyc(4'hF, 1'b0, 5'b11100, 16'hBEEF);

        // Length-2 frame, reset asserted right after the first strobe.
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h0, 1'b0, 5'b00001, 16'h0);
        cyc(4'h2, 1'b0, 5'b00001, 16'h0);
        cyc(4'h1, 1'b0, 5'b00001, 16'h0);
        cyc(4'h2, 1'b0, 5'b00001, 16'h0);
        cyc(4'h3, 1'b0, 5'b00001, 16'h0);
        cyc(4'h4, 1'b0, 5'b11001, 16'h1234);
        reset = 1'b1;
        #1;
        check("async reset flags", {11'd0, dout_valid, sof, eof, frame_err, frame_active}, 16'd0);
        check("async reset dout", dout, 16'h0000);
        din = 4'h5;
        repeat (2) @(posedge clk80);
        #1;
        check("reset held flags", {11'd0, dout_valid, sof, eof, frame_err, frame_active}, 16'd0);
        reset = 1'b0;

        // Back in HUNT: a lone F is ignored, then a new marker is accepted.
        cyc(4'hF, 1'b0, 5'b00000, 16'h0);
        cyc(4'h6, 1'b0, 5'b00000, 16'h0);
        cyc(4'h7, 1'b0, 5'b00000, 16'h0);
        cyc(4'hF, 1'b0, 5'b00001, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nrzi_4b5b_deframer.md
Name: nrzi_4b5b_deframer

Overview:
- Stage directly downstream of the NRZI/4B5B symbol decoder in the deser400 receive path.
- Takes one decoded 4-bit symbol plus its error flag every clk80 cycle.
- Hunts for a two-nibble sync marker, reads a 12-bit payload length, then packs payload nibbles MSN-first into 16-bit words, tagging start and end of frame.
- Aborts with a flag on symbol errors or bad lengths, then re-hunts.

Parameters:
- SYNC0, 4'h7, first sync nibble.
- SYNC1, 4'hF, second sync nibble.
- MAX_WORDS, 256, largest legal payload length in words, range 1..4095.

Ports:
- clk80  input  1  80 MHz symbol clock; one symbol per cycle.
- reset  input  1  asynchronous, active-high reset.
- din  input  4  decoded symbol from the 4B5B decoder.
- din_err  input  1  symbol-invalid flag, aligned with din.
- dout  output  16  assembled payload word, first-received nibble in [15:12].
- dout_valid  output  1  one-cycle strobe; dout is valid while high.
- sof  output  1  high with dout_valid on the first payload word.
- eof  output  1  high with dout_valid on the last payload word.
- frame_err  output  1  one-cycle pulse on abort or bad length.
- frame_active  output  1  high while in LENGTH or PAYLOAD.

Behaviour:
- Interface: single clock clk80. Reset is asynchronous and active-high; all state clears immediately on assertion.
- Reset values: dout=0, dout_valid=0, sof=0, eof=0, frame_err=0, frame_active=0, state=HUNT, all counters 0.
- All outputs are registered. dout_valid/sof/eof/frame_err are single-cycle pulses, default 0.
- State HUNT:
  - din==SYNC0 with din_err=0 -> SYNC.
  - Anything else, including idle 4'hA and error symbols, stays in HUNT and is ignored.
- State SYNC:
  - din==SYNC1, no error -> LENGTH; nibble counter cleared.
  - din==SYNC0, no error -> stay in SYNC (handles 7,7,F).
  - Otherwise -> HUNT. No frame_err.
- State LENGTH: shift in 3 nibbles MSN-first to form len[11:0]. On the 3rd nibble:
  - len==0 or len>MAX_WORDS -> frame_err=1 next cycle, go to HUNT.
  - Otherwise -> PAYLOAD; word counter=0, nibble counter=0.
- State PAYLOAD:
  - Shift in nibbles MSN-first.
  - On the 4th nibble of a word, the following cycle drives dout=word and dout_valid=1.
  - sof=1 on word 0; eof=1 on word len-1. Both are set when len==1.
  - After the last word's 4th nibble -> HUNT.
  - The next cycle's symbol is already evaluated in HUNT, so back-to-back frames with zero gap work.
- Latency: dout_valid rises exactly one clk80 after the cycle presenting the word's 4th nibble.
- din_err=1 in LENGTH or PAYLOAD:
  - Immediate abort: frame_err=1 next cycle, go to HUNT, partial word discarded.
  - No eof is ever issued for an aborted frame.
  - Words already emitted stand; consumers treat frame_err after sof without eof as truncation.
  - An erroring symbol is never taken as SYNC0 in the same cycle.
- frame_active: 1 from the cycle after SYNC1 is accepted until the cycle after the final nibble or abort.
- Counters: nibble counter 2 bits, wraps 3->0 per word; word counter 12 bits, compared against len-1. No overflow is possible because len ≤ MAX_WORDS ≤ 4095.
- Reset mid-frame: all outputs drop in the same instant. Any in-flight dout_valid is lost; no frame_err is generated.

Test Plan:
- Reset, then idle stream of 4'hA -> dout_valid, frame_err and frame_active stay 0; dout=0.
- Stream 7,F,0,0,2,1,2,3,4,A,B,C,D -> two strobes: 0x1234 with sof=1/eof=0, then 0xABCD with sof=0/eof=1. Each strobe lands one cycle after its 4th nibble; frame_active falls afterwards.
- Stream 7,7,F,0,0,1,5,6,7,8 -> single strobe 0x5678 with sof=eof=1. Then stream 7,3,F -> no frame starts.
- Length 0 (7,F,0,0,0), then length 0x101 with MAX_WORDS=256 -> frame_err pulse each time, no dout_valid, back in HUNT.
- Frame of len 3 with din_err on the 2nd nibble of word 1 -> word 0 emitted with sof, then frame_err pulse. No further strobes and no eof; a following valid frame decodes correctly.
- Two len-1 frames with zero gap, then reset asserted mid-payload -> both words emitted with sof=eof=1. On reset, outputs clear asynchronously and state returns to HUNT.
